// File: rtl/mips_instruction_opfunc_encoder.sv
// Packs an OpFunc tag plus operand fields into a 32-bit MIPS word, queued in a DEPTH-entry output FIFO.
// Optional illegal-OpFunc drop/error counting is built when MIPS_INSTRUCTION_OPFUNC_ENCODER_CHECK_EN is defined.
module mips_instruction_opfunc_encoder #(
    parameter int DEPTH   = 2,
    parameter int COUNT_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         in_opfunc,
    input  logic [4:0]         in_rs,
    input  logic [4:0]         in_rt,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_shamt,
    input  logic [25:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_inst,
    output logic [COUNT_W-1:0] enc_count,
    output logic               err_pulse,
    output logic [COUNT_W-1:0] err_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [31:0]      encoded;
    logic [5:0]       code;
    logic             legal;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign code = in_opfunc[5:0];

    always_comb begin
        encoded = '0;
        if (!in_opfunc[6]) begin
            encoded = {6'h00, in_rs, in_rt, in_rd, in_shamt, code};
        end else if (code == 6'h02 || code == 6'h03) begin
            encoded = {code, in_imm};
        end else begin
            encoded = {code, in_rs, in_rt, in_imm[15:0]};
        end
    end

`ifdef MIPS_INSTRUCTION_OPFUNC_ENCODER_CHECK_EN
    // Op code 0 would decode back as a Func word, so it is swallowed and counted instead.
    assign legal = !(in_opfunc[6] && code == 6'h00);

    logic               err_pulse_q;
    logic [COUNT_W-1:0] err_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= in_valid && in_ready && !legal;
            if (in_valid && in_ready && !legal) begin
                err_count_q <= err_count_q + COUNT_W'(1);
            end
        end
    end

    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
`else
    assign legal     = 1'b1;
    assign err_pulse = 1'b0;
    assign err_count = '0;
`endif

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    // Ready depends only on stored occupancy, so a pop frees a slot one cycle later.
    assign in_ready  = !full && !reset;
    assign out_valid = !empty;
    assign out_inst  = empty ? 32'h0 : mem[rd_ptr];

    assign push = in_valid && in_ready && legal;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= encoded;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            enc_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                enc_count <= enc_count + COUNT_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
